// File: rtl/fft_iter_core.sv
// Iterative radix-2 DIT FFT/IFFT: loads N samples bit-reversed, runs (N/2)*LOGN in-place butterflies, unloads N bins.
// Optional macro FFT_INV_SCALE_EN: inverse frames are divided by N (arithmetic shift) on the unload read.
module fft_iter_core #(
    parameter int N    = 16,
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int TW   = 16,
    parameter int LOGN = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [W-1:0]      in_re,
    input  logic signed [W-1:0]      in_im,
    input  logic                     inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [W+LOGN-1:0] out_re,
    output logic signed [W+LOGN-1:0] out_im,
    output logic [LOGN-1:0]          out_idx,
    output logic                     out_last,
    output logic                     busy
);
    localparam int DW = W + LOGN;
    localparam int BW = LOGN - 1;
    localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int PW = DW + TW + 1;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_COMP = 2'd1;
    localparam logic [1:0] S_UNLD = 2'd2;

    if (N < 4 || N > 1024 || (N & (N - 1)) != 0 || FRAC >= W || TW < 3) begin : g_param_chk
        $error("fft_iter_core: unsupported parameter set");
    end

    function automatic logic signed [TW-1:0] tw_rom(input int k, input bit want_sin);
        real ang, v;
        ang = 6.283185307179586 * real'(k) / real'(N);
        v   = (want_sin ? $sin(ang) : $cos(ang)) * real'(1 << (TW - 2));
        v   = (v >= 0.0) ? v + 0.5 : v - 0.5;
        return TW'($rtoi(v));
    endfunction

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        for (int i = 0; i < LOGN; i++) bitrev[i] = a[LOGN-1-i];
    endfunction

    // Twiddles are elaboration constants; index 0 rounds to exactly 1 << (TW-2).
    logic signed [TW-1:0] cos_rom [N/2];
    logic signed [TW-1:0] sin_rom [N/2];
    for (genvar g = 0; g < N/2; g++) begin : g_tw
        localparam logic signed [TW-1:0] C = tw_rom(g, 1'b0);
        localparam logic signed [TW-1:0] S = tw_rom(g, 1'b1);
        assign cos_rom[g] = C;
        assign sin_rom[g] = S;
    end

    logic [1:0]      state_q, state_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic            inv_q, inv_d;

    logic signed [DW-1:0] mem_re [N];
    logic signed [DW-1:0] mem_im [N];

    logic [LOGN-1:0]      bf, half, j, top, bot;
    logic [BW-1:0]        tw_idx;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [PW-1:0] p_re, p_im;

    always_comb begin
        bf     = {1'b0, cnt_q[BW-1:0]};
        half   = LOGN'(1) << stage_q;
        j      = bf & (half - LOGN'(1));
        top    = (((bf >> stage_q) << 1) << stage_q) | j;
        bot    = top | half;
        tw_idx = BW'(j << (SW'(LOGN - 1) - stage_q));
        a_re   = mem_re[top];
        a_im   = mem_im[top];
        b_re   = mem_re[bot];
        b_im   = mem_im[bot];
        w_re   = cos_rom[tw_idx];
        w_im   = inv_q ? sin_rom[tw_idx] : -sin_rom[tw_idx];
        // Full-precision product, then floor-shift back to sample scale.
        p_re   = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        p_im   = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        t_re   = DW'(p_re >>> (TW - 2));
        t_im   = DW'(p_im >>> (TW - 2));
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid) begin
            mem_re[bitrev(cnt_q)] <= {{LOGN{in_re[W-1]}}, in_re};
            mem_im[bitrev(cnt_q)] <= {{LOGN{in_im[W-1]}}, in_im};
        end else if (state_q == S_COMP) begin
            mem_re[top] <= a_re + t_re;
            mem_im[top] <= a_im + t_im;
            mem_re[bot] <= a_re - t_re;
            mem_im[bot] <= a_im - t_im;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        case (state_q)
            S_LOAD: if (in_valid) begin
                if (cnt_q == '0) inv_d = inv;
                if (cnt_q == LOGN'(N - 1)) begin
                    state_d = S_COMP;
                    cnt_d   = '0;
                    stage_d = '0;
                end else begin
                    cnt_d = cnt_q + LOGN'(1);
                end
            end
            S_COMP: if (cnt_q[BW-1:0] == {BW{1'b1}}) begin
                cnt_d = '0;
                if (stage_q == SW'(LOGN - 1)) state_d = S_UNLD;
                else                          stage_d = stage_q + SW'(1);
            end else begin
                cnt_d = cnt_q + LOGN'(1);
            end
            S_UNLD: if (out_ready) begin
                if (cnt_q == LOGN'(N - 1)) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LOGN'(1);
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
        end
    end

    logic signed [DW-1:0] rd_re, rd_im, sc_re, sc_im;
    assign rd_re = mem_re[cnt_q];
    assign rd_im = mem_im[cnt_q];
`ifdef FFT_INV_SCALE_EN
    assign sc_re = inv_q ? (rd_re >>> LOGN) : rd_re;
    assign sc_im = inv_q ? (rd_im >>> LOGN) : rd_im;
`else
    assign sc_re = rd_re;
    assign sc_im = rd_im;
`endif

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_UNLD);
    assign out_idx   = out_valid ? cnt_q : '0;
    assign out_last  = out_valid && (cnt_q == LOGN'(N - 1));
    assign out_re    = out_valid ? sc_re : '0;
    assign out_im    = out_valid ? sc_im : '0;
    assign busy      = (state_q != S_LOAD) || (cnt_q != '0);
endmodule

// File: tb/tb_fft_iter_core.sv
// Scoreboard bench for fft_iter_core (N=16): expected bins queued with each frame, popped per output handshake.
module tb_fft_iter_core;
    localparam int N = 16, W = 16, FRAC = 8, TW = 16, LOGN = 4, DW = W + LOGN;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [W-1:0]  in_re = '0, in_im = '0;
    logic                 inv = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_re, out_im;
    logic [LOGN-1:0]      out_idx;
    logic                 out_last;
    logic                 busy;

    fft_iter_core #(.N(N), .W(W), .FRAC(FRAC), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .inv(inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int re; int im; int tol; } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0, acc_cyc = 0;
    logic signed [W-1:0] st_re [N];
    logic signed [W-1:0] st_im [N];

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    endfunction

    function automatic void push_exp(input int re, input int im, input int tol);
        exp_t e;
        e.re = re; e.im = im; e.tol = tol;
        sb.push_back(e);
    endfunction

    function automatic void clear_stim();
        for (int k = 0; k < N; k++) begin st_re[k] = '0; st_im[k] = '0; end
    endfunction

    // x[1] = a -> X[k] = a * exp(-2*pi*i*k/N)
    function automatic void fill_delayed(input int a);
        clear_stim();
        st_re[1] = W'(a);
        for (int k = 0; k < N; k++)
            push_exp(rnd(a * $cos(6.283185307179586 * k / N)), rnd(-a * $sin(6.283185307179586 * k / N)), 2);
    endfunction

    task automatic send_frame(input logic inv_b);
        for (int k = 0; k < N; k++) begin
            int guard = 0;
            @(negedge clk);
            in_valid = 1'b1; in_re = st_re[k]; in_im = st_im[k];
            inv = (k == 0) ? inv_b : ~inv_b;
            while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
            if (!in_ready) begin
                total++; bad++;
                $display("FAIL send_timeout k=%0d in_ready=%b required 1", k, in_ready);
                in_valid = 1'b0;
                return;
            end
            acc_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0; in_re = '0; in_im = '0; inv = 1'b0;
    endtask

    task automatic recv_frame(input string name, input bit rnd_rdy, input bit chk_lat, input bit overlap);
        int got = 0, guard = 0;
        bit stalled = 0, first = 1;
        logic signed [DW-1:0] h_re = '0, h_im = '0;
        logic [LOGN-1:0] h_idx = '0;
        exp_t e;
        while (got < N && guard < 400) begin
            @(negedge clk); guard++;
            if (!out_valid) begin out_ready = 1'b1; continue; end
            if (first) begin
                first = 0;
                if (chk_lat) begin
                    total++;
                    if (cyc - acc_cyc != 33) begin
                        bad++; $display("FAIL %s latency got=%0d required=33", name, cyc - acc_cyc);
                    end
                end
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_unload got=%b required 1", name, busy); end
            end
            if (stalled) begin
                total++;
                if (out_re !== h_re || out_im !== h_im || out_idx !== h_idx) begin
                    bad++;
                    $display("FAIL %s stall_hold got=%0d,%0d idx=%0d required=%0d,%0d idx=%0d",
                             name, out_re, out_im, out_idx, h_re, h_im, h_idx);
                end
            end
            out_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (!out_ready) begin
                stalled = 1; h_re = out_re; h_im = out_im; h_idx = out_idx;
                continue;
            end
            stalled = 0;
            total++;
            if (sb.size() == 0) begin
                bad++; $display("FAIL %s scoreboard_empty bin=%0d", name, got);
            end else begin
                e = sb.pop_front();
                if ($isunknown({out_re, out_im}) ||
                    int'(out_re) - e.re > e.tol || e.re - int'(out_re) > e.tol ||
                    int'(out_im) - e.im > e.tol || e.im - int'(out_im) > e.tol) begin
                    bad++;
                    $display("FAIL %s bin=%0d got=%0d,%0d required=%0d,%0d tol=%0d",
                             name, got, out_re, out_im, e.re, e.im, e.tol);
                end
            end
            total++;
            if (out_idx !== LOGN'(got) || out_last !== (got == N - 1)) begin
                bad++;
                $display("FAIL %s idx_last got idx=%0d last=%b required idx=%0d last=%b",
                         name, out_idx, out_last, got, (got == N - 1));
            end
            if (overlap && got == N - 1) begin
                in_valid = 1'b1; in_re = 16'sd999; in_im = -16'sd999;
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL %s overlap_in_ready got=%b required 0", name, in_ready); end
            end
            got++;
        end
        if (got < N) begin
            total++; bad++;
            $display("FAIL %s recv_timeout got=%0d bins required=%0d", name, got, N);
        end
        @(negedge clk);
        in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
        total++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            bad++;
            $display("FAIL %s post_frame got in_ready/busy/out_valid=%b required 100", name, {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, busy, out_last} !== 4'b1000) begin
            bad++; $display("FAIL reset_flags got=%b required 1000", {in_ready, out_valid, busy, out_last});
        end
        total++;
        if (out_idx !== '0 || out_re !== '0 || out_im !== '0) begin
            bad++; $display("FAIL reset_outputs got idx=%0d re=%0d im=%0d required 0", out_idx, out_re, out_im);
        end
    endtask

    task automatic test_impulse();
        clear_stim();
        st_re[0] = 16'sd256;
        for (int k = 0; k < N; k++) push_exp(256, 0, 0);
        send_frame(1'b0);
        recv_frame("impulse", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_dc();
        for (int k = 0; k < N; k++) begin st_re[k] = 16'sd256; st_im[k] = '0; end
        for (int k = 0; k < N; k++) push_exp((k == 0) ? 4096 : 0, 0, 0);
        send_frame(1'b0);
        recv_frame("dc", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_tone();
        for (int k = 0; k < N; k++) begin
            case (k % 4)
                0: begin st_re[k] =  16'sd256; st_im[k] =  16'sd0;   end
                1: begin st_re[k] =  16'sd0;   st_im[k] = -16'sd256; end
                2: begin st_re[k] = -16'sd256; st_im[k] =  16'sd0;   end
                default: begin st_re[k] = 16'sd0; st_im[k] = 16'sd256; end
            endcase
        end
        for (int k = 0; k < N; k++) push_exp((k == 12) ? 4096 : 0, 0, 2);
        send_frame(1'b0);
        recv_frame("tone", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_inverse();
        int want;
`ifdef FFT_INV_SCALE_EN
        want = 256;
`else
        want = 4096;
`endif
        clear_stim();
        st_re[0] = 16'sd4096;
        for (int k = 0; k < N; k++) push_exp(want, 0, 0);
        send_frame(1'b1);
        recv_frame("inverse", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        fill_delayed(768);
        send_frame(1'b0);
        recv_frame("back_to_back", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_delayed(1024);
        send_frame(1'b0);
        recv_frame("backpressure", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        for (int k = 0; k < N; k++) begin st_re[k] = 16'sd256; st_im[k] = 16'sd128; end
        send_frame(1'b0);
        repeat (9) @(negedge clk);
        total++;
        if ({busy, out_valid, in_ready} !== 3'b100) begin
            bad++; $display("FAIL abort_precompute got busy/out_valid/in_ready=%b required 100", {busy, out_valid, in_ready});
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, busy, out_last} !== 4'b1000 || out_idx !== '0 || out_re !== '0 || out_im !== '0) begin
            bad++;
            $display("FAIL abort_reset got flags=%b idx=%0d re=%0d im=%0d required flags=1000 zeros",
                     {in_ready, out_valid, busy, out_last}, out_idx, out_re, out_im);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill_delayed(512);
        send_frame(1'b0);
        recv_frame("after_abort", 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required completion", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_tone();
        test_inverse();
        test_back_to_back();
        test_backpressure();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
